track_memory_sequencer: RTL and testbench

- Command responder for the recorder control FSM. Consumes its write/read/track1/track2/mixtrack/clean strobes.
- Stores recorded tone words into one of two track memories.
- On read, plays back the selected track (or the OR-mix of both), one note per NOTE_TICKS clocks, then pulses finish back to the control FSM.
- Sits between the control FSM and the tone generator.

---
 rtl/track_memory_sequencer_pkg.sv | 25 ++
 rtl/track_memory_sequencer_ram.sv | 26 ++
 rtl/track_memory_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_track_memory_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/track_memory_sequencer_pkg.sv
// Shared definitions for the track memory sequencer: track-select codes,
// playback FSM state encoding and track depth.
package track_memory_sequencer_pkg;

    localparam int ADDR_W_DEFAULT = 6;

    // Number of notes a track can hold for a given address width.
    function automatic int depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

    localparam int DEPTH = depth(ADDR_W_DEFAULT);

    localparam logic [1:0] SEL_TRACK1 = 2'd0;
    localparam logic [1:0] SEL_TRACK2 = 2'd1;
    localparam logic [1:0] SEL_MIX    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/track_memory_sequencer_ram.sv
// One track of tone storage: single-port RAM with registered read, no reset
// so it maps onto block RAM. Contents survive reset and clean.
module track_ram
    import track_memory_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int TONE_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [TONE_W-1:0] din,
    output logic [TONE_W-1:0] dout
);

    logic [TONE_W-1:0] mem [2**ADDR_W];

    // Write-first is not needed: reads and writes never target the same cycle.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/track_memory_sequencer.sv
// Records tone words into two tracks and plays back one track or the OR-mix
// of both, one note per NOTE_TICKS clocks, pulsing finish when done.
module track_memory_sequencer
    import track_memory_sequencer_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int TONE_W     = 8,
    parameter int NOTE_TICKS = 12500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic              track1,
    input  logic              track2,
    input  logic              mixtrack,
    input  logic              clean,
    input  logic [TONE_W-1:0] swTones,
    output logic [TONE_W-1:0] tone_out,
    output logic              tone_valid,
    output logic              finish,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   len1,
    output logic [ADDR_W:0]   len2,
    output logic [1:0]        sel
);

    localparam int TICK_W = (NOTE_TICKS > 2) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(NOTE_TICKS - 1);
    localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W + 1)'(depth(ADDR_W));

    state_t            state_reg;
    logic [1:0]        sel_reg;
    logic [ADDR_W:0]   len_reg [2];
    logic [ADDR_W:0]   idx_reg;
    logic [ADDR_W:0]   plen_reg;
    logic [TICK_W-1:0] tick_reg;
    logic [TONE_W-1:0] tone_reg;
    logic              valid_reg;
    logic              finish_reg;
    logic              read_d_reg;

    logic              idle;
    logic              sel_cmd;
    logic              wr_ok;
    logic              start_ok;
    logic [ADDR_W:0]   len_longest;
    logic [ADDR_W:0]   plen_next;
    logic [TONE_W-1:0] tone_next;

    logic              ram_we   [2];
    logic [ADDR_W-1:0] ram_addr [2];
    logic [TONE_W-1:0] ram_dout [2];
    logic [TONE_W-1:0] contrib  [2];

    // Command decode: only one command acts per idle cycle, highest priority wins.
    assign idle     = (state_reg == ST_IDLE);
    assign sel_cmd  = track1 | track2 | mixtrack;
    assign wr_ok    = idle && !clean && !sel_cmd && write &&
                      (sel_reg != SEL_MIX) && (len_reg[sel_reg[0]] != LEN_MAX);
    assign start_ok = idle && !clean && !sel_cmd && !write && read && !read_d_reg;

    assign len_longest = (len_reg[0] > len_reg[1]) ? len_reg[0] : len_reg[1];
    assign plen_next   = (sel_reg == SEL_MIX) ? len_longest : len_reg[sel_reg[0]];

    // Per-track RAMs; a track past its recorded length adds nothing to the mix.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_track
            assign ram_we[gi]   = wr_ok && (sel_reg == 2'(gi));
            assign ram_addr[gi] = idle ? len_reg[gi][ADDR_W-1:0] : idx_reg[ADDR_W-1:0];
            assign contrib[gi]  = (idx_reg < len_reg[gi]) ? ram_dout[gi] : '0;

            track_ram #(
                .ADDR_W (ADDR_W),
                .TONE_W (TONE_W)
            ) u_ram (
                .clock (clock),
                .we    (ram_we[gi]),
                .addr  (ram_addr[gi]),
                .din   (swTones),
                .dout  (ram_dout[gi])
            );
        end
    endgenerate

    assign tone_next = (sel_reg == SEL_MIX) ? (contrib[0] | contrib[1]) : ram_dout[sel_reg[0]];

    // Command handling plus playback FSM; outputs are registered one cycle behind the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            sel_reg    <= SEL_TRACK1;
            len_reg[0] <= '0;
            len_reg[1] <= '0;
            idx_reg    <= '0;
            plen_reg   <= '0;
            tick_reg   <= '0;
            tone_reg   <= '0;
            valid_reg  <= 1'b0;
            finish_reg <= 1'b0;
            read_d_reg <= 1'b0;
        end else begin
            read_d_reg <= read;
            finish_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tone_reg  <= '0;
                    valid_reg <= 1'b0;
                    if (clean) begin
                        len_reg[0] <= '0;
                        len_reg[1] <= '0;
                        if (track1) begin
                            sel_reg <= SEL_TRACK1;
                        end else if (track2) begin
                            sel_reg <= SEL_TRACK2;
                        end
                    end else if (sel_cmd) begin
                        if (track1) begin
                            sel_reg <= SEL_TRACK1;
                        end else if (track2) begin
                            sel_reg <= SEL_TRACK2;
                        end else begin
                            sel_reg <= SEL_MIX;
                        end
                    end else if (wr_ok) begin
                        len_reg[sel_reg[0]] <= len_reg[sel_reg[0]] + 1'b1;
                    end else if (start_ok) begin
                        idx_reg   <= '0;
                        plen_reg  <= plen_next;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    valid_reg <= 1'b0;
                    if (!read) begin
                        tone_reg  <= '0;
                        state_reg <= ST_IDLE;
                    end else if (idx_reg == plen_reg) begin
                        state_reg <= ST_DONE;
                    end else begin
                        tick_reg  <= '0;
                        state_reg <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!read) begin
                        tone_reg  <= '0;
                        valid_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        // RAM data for idx is valid during the first hold cycle.
                        if (tick_reg == '0) begin
                            tone_reg  <= tone_next;
                            valid_reg <= 1'b1;
                        end
                        if (tick_reg == TICK_LAST) begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= ST_FETCH;
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    tone_reg   <= '0;
                    valid_reg  <= 1'b0;
                    finish_reg <= read;
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tone_out   = tone_reg;
    assign tone_valid = valid_reg;
    assign finish     = finish_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign len1       = len_reg[0];
    assign len2       = len_reg[1];
    assign sel        = sel_reg;
    assign full       = (sel_reg == SEL_MIX) ?
                        ((len_reg[0] == LEN_MAX) && (len_reg[1] == LEN_MAX)) :
                        (len_reg[sel_reg[0]] == LEN_MAX);

endmodule

// File: tb/tb_track_memory_sequencer.sv
// Bench for track_memory_sequencer: directed scenarios followed by random
// command rounds, checked against a behavioural model of tracks and timing.
`timescale 1ns/1ps
module tb_track_memory_sequencer;
    import track_memory_sequencer_pkg::*;

    localparam int ADDR_W = 6;
    localparam int TONE_W = 8;
    localparam int NT     = 4;
    localparam int P      = NT + 1;

    logic              clock = 1'b0;
    logic              reset, write, read, track1, track2, mixtrack, clean;
    logic [TONE_W-1:0] swTones, tone_out;
    logic              tone_valid, finish, busy, full;
    logic [ADDR_W:0]   len1, len2;
    logic [1:0]        sel;

    always #5 clock = ~clock;

    track_memory_sequencer #(
        .ADDR_W     (ADDR_W),
        .TONE_W     (TONE_W),
        .NOTE_TICKS (NT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .write      (write),
        .read       (read),
        .track1     (track1),
        .track2     (track2),
        .mixtrack   (mixtrack),
        .clean      (clean),
        .swTones    (swTones),
        .tone_out   (tone_out),
        .tone_valid (tone_valid),
        .finish     (finish),
        .busy       (busy),
        .full       (full),
        .len1       (len1),
        .len2       (len2),
        .sel        (sel)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model: recorded notes per track, lengths and selection.
    logic [7:0] mem_m [2][DEPTH];
    int         len_m [2];
    int         sel_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic exp_full();
        if (sel_m == 2) return (len_m[0] == DEPTH) && (len_m[1] == DEPTH);
        return len_m[sel_m] == DEPTH;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, "/len1"}, len1, len_m[0]);
        check_eq({tag, "/len2"}, len2, len_m[1]);
        check_eq({tag, "/sel"},  sel,  sel_m);
        check_eq({tag, "/full"}, full, exp_full());
        check_eq({tag, "/busy"}, busy, 0);
    endtask

    // One idle-cycle command; model applies clean > select > write priority.
    task automatic issue(input logic c, input logic t1, input logic t2,
                         input logic mx, input logic wr, input logic [7:0] d);
        clean = c; track1 = t1; track2 = t2; mixtrack = mx; write = wr; swTones = d;
        step();
        clean = 0; track1 = 0; track2 = 0; mixtrack = 0; write = 0;
        if (c) begin
            len_m[0] = 0;
            len_m[1] = 0;
            if (t1) sel_m = 0;
            else if (t2) sel_m = 1;
        end else if (t1 || t2 || mx) begin
            sel_m = t1 ? 0 : (t2 ? 1 : 2);
        end else if (wr && sel_m != 2 && len_m[sel_m] < DEPTH) begin
            mem_m[sel_m][len_m[sel_m]] = d;
            len_m[sel_m]++;
        end
        $display("cmd clean=%0d t1=%0d t2=%0d mix=%0d wr=%0d d=%02h -> len1=%0d len2=%0d sel=%0d",
                 c, t1, t2, mx, wr, d, len1, len2, sel);
        check_state("cmd");
    endtask

    // Playback: mode 0 runs to completion, 1 drops read before edge stop_k,
    // 2 asserts reset before edge stop_k (edges counted from read-start).
    task automatic play(input string name, input int mode, input int stop_k);
        logic [7:0] notes [$];
        int plen, kend, j;
        plen = (sel_m == 2) ? ((len_m[0] > len_m[1]) ? len_m[0] : len_m[1]) : len_m[sel_m];
        for (int i = 0; i < plen; i++) begin
            if (sel_m == 2)
                notes.push_back(((i < len_m[0]) ? mem_m[0][i] : 8'h00) |
                                ((i < len_m[1]) ? mem_m[1][i] : 8'h00));
            else
                notes.push_back(mem_m[sel_m][i]);
        end
        read = 1;
        step();
        check_eq({name, "/busy_start"}, busy, 1);
        kend = (mode == 0) ? (2 + plen * P + 1) : stop_k;
        for (int k = 1; k <= kend; k++) begin
            if (mode == 1 && k == stop_k) read = 0;
            if (mode == 2 && k == stop_k) reset = 1;
            step();
            if (mode != 0 && k == stop_k) begin
                check_eq({name, "/stop_tone"},   tone_out,   0);
                check_eq({name, "/stop_valid"},  tone_valid, 0);
                check_eq({name, "/stop_busy"},   busy,       0);
                check_eq({name, "/stop_finish"}, finish,     0);
                if (mode == 2) begin
                    reset = 0;
                    read = 0;
                    len_m[0] = 0;
                    len_m[1] = 0;
                    sel_m = 0;
                    check_state({name, "/after_reset"});
                end
            end else begin
                j = k - 2;
                if (k >= 2 && j < plen * P) begin
                    if (j % P < NT) begin
                        check_eq({name, "/valid"}, tone_valid, 1);
                        check_eq({name, "/tone"},  tone_out,   notes[j / P]);
                    end else begin
                        check_eq({name, "/gap_valid"}, tone_valid, 0);
                    end
                end else begin
                    check_eq({name, "/idle_valid"}, tone_valid, 0);
                    check_eq({name, "/idle_tone"},  tone_out,   0);
                end
                check_eq({name, "/finish"}, finish, (k == 2 + plen * P) ? 1 : 0);
                check_eq({name, "/busy"},   busy,   (k <= plen * P + 1) ? 1 : 0);
            end
        end
        // Read stays high (mode 0) or low (abort/reset): nothing may restart.
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq({name, "/quiet_busy"},   busy,       0);
            check_eq({name, "/quiet_finish"}, finish,     0);
            check_eq({name, "/quiet_valid"},  tone_valid, 0);
        end
        read = 0;
        step();
        $display("play %s sel=%0d notes=%0d mode=%0d", name, sel_m, plen, mode);
        check_state({name, "/end"});
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, op;
        logic [7:0] d;
        reset = 1; write = 0; read = 0; track1 = 0; track2 = 0;
        mixtrack = 0; clean = 0; swTones = 0;
        len_m[0] = 0; len_m[1] = 0; sel_m = 0;
        repeat (3) step();
        check_eq("reset/tone",   tone_out,   0);
        check_eq("reset/valid",  tone_valid, 0);
        check_eq("reset/finish", finish,     0);
        check_eq("reset/busy",   busy,       0);
        check_eq("reset/full",   full,       0);
        check_eq("reset/len1",   len1,       0);
        check_eq("reset/len2",   len2,       0);
        check_eq("reset/sel",    sel,        0);
        reset = 0;
        step();

        // Store and play back track 1.
        issue(0, 1, 0, 0, 0, 8'h00);
        issue(0, 0, 0, 0, 1, 8'h01);
        issue(0, 0, 0, 0, 1, 8'h04);
        issue(0, 0, 0, 0, 1, 8'h80);
        play("track1", 0, 0);

        // Mix playback; a write in mix mode is ignored.
        issue(1, 1, 0, 0, 0, 8'h00);
        issue(0, 0, 0, 0, 1, 8'h01);
        issue(0, 0, 0, 0, 1, 8'h02);
        issue(0, 0, 1, 0, 0, 8'h00);
        issue(0, 0, 0, 0, 1, 8'h10);
        issue(0, 0, 0, 1, 0, 8'h00);
        issue(0, 0, 0, 0, 1, 8'hFF);
        play("mix", 0, 0);

        // Full track 2: 65 writes, last one dropped.
        issue(1, 0, 1, 0, 0, 8'h00);
        issue(0, 0, 0, 0, 1, 8'hA5);
        for (int i = 1; i < DEPTH + 1; i++) issue(0, 0, 0, 0, 1, 8'(i + 8'h20));
        play("full", 0, 0);

        // Empty track after clean.
        issue(1, 1, 0, 0, 0, 8'h00);
        play("empty", 0, 0);

        // Abort during the second note, then restart from note 0.
        issue(0, 0, 0, 0, 1, 8'h11);
        issue(0, 0, 0, 0, 1, 8'h22);
        issue(0, 0, 0, 0, 1, 8'h33);
        play("abort", 1, P + 3);
        play("restart", 0, 0);

        // Reset during the first note's hold.
        play("reset", 2, 3);

        // Random command rounds, each followed by a playback.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 10);
            for (int c = 0; c < n; c++) begin
                op = $urandom_range(0, 19);
                d = 8'($urandom);
                if (op == 0)
                    issue(1, 1'($urandom), 1'($urandom), 0, 1'($urandom), d);
                else if (op <= 3)
                    issue(0, 1'($urandom), 1'($urandom), 1, 1'($urandom), d);
                else if (op <= 5)
                    issue(0, op == 4, op == 5, 0, 1'($urandom), d);
                else
                    issue(0, 0, 0, 0, 1, d);
            end
            if ($urandom_range(0, 3) == 0) play("rand_abort", 1, $urandom_range(1, 8));
            else play("rand", 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
